rr_dec_arbiter4: RTL

Four-requester round-robin arbiter that shares one downstream resource. The resource is selected by a 2-to-4 one-hot decode of the granted index. The block registers a grant index, drives the one-hot enables the decoder would produce (gated by a global enable), and limits each grant to a bounded hold time. It sits between four requesting units and the shared 2-to-4 decoded select path.

---
 rtl/rr_dec_arbiter4.sv | 115 +++++++++++
 1 files changed

// File: rtl/rr_dec_arbiter4.sv
// Four-requester round-robin arbiter with bounded hold time. Drives a registered
// grant index plus its one-hot decode, both forced idle when en is low.
module rr_dec_arbiter4 #(
   parameter int MAX_HOLD = 4,
   parameter int HOLD_W   = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   state_t            state_reg, state_next;
   logic [1:0]        ptr_reg, ptr_next;
   logic [1:0]        idx_reg, idx_next;
   logic [HOLD_W-1:0] hold_reg, hold_next;
   logic              valid_reg, valid_next;
   logic [3:0]        gnt_reg, gnt_next;
   logic              release_now;

   // First set request bit scanning cyclically from start; scanning high to low
   // lets the nearest candidate overwrite the farther ones.
   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
      logic [1:0] sel;
      logic [1:0] cand;
      sel = start;
      for (int k = 3; k >= 0; k--) begin
         cand = start + 2'(k);
         if (r[cand]) sel = cand;
      end
      return sel;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         ptr_reg   <= 2'b00;
         idx_reg   <= 2'b00;
         hold_reg  <= '0;
         valid_reg <= 1'b0;
         gnt_reg   <= 4'b0000;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         idx_reg   <= idx_next;
         hold_reg  <= hold_next;
         valid_reg <= valid_next;
         gnt_reg   <= gnt_next;
      end
   end

   assign release_now = !en || !req[idx_reg] || (hold_reg == HOLD_LAST);

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      idx_next   = idx_reg;
      hold_next  = hold_reg;
      valid_next = valid_reg;
      case (state_reg)
         IDLE: begin
            valid_next = 1'b0;
            hold_next  = '0;
            if (en && (req != 4'b0000)) begin
               idx_next   = pick(req, ptr_reg);
               valid_next = 1'b1;
               state_next = GRANT;
            end
         end
         GRANT: begin
            if (release_now) begin
               // Scanning from owner+1 puts a still-requesting owner last in line.
               ptr_next  = idx_reg + 2'd1;
               hold_next = '0;
               if (en && (req != 4'b0000)) begin
                  idx_next   = pick(req, idx_reg + 2'd1);
                  valid_next = 1'b1;
               end else begin
                  valid_next = 1'b0;
                  state_next = IDLE;
               end
            end else begin
               hold_next = hold_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            valid_next = 1'b0;
            hold_next  = '0;
         end
      endcase
   end

   // One-hot decode of the next owner, registered alongside the index.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_dec
         assign gnt_next[gi] = valid_next && (idx_next == 2'(gi));
      end
   endgenerate

   assign gnt       = gnt_reg;
   assign gnt_idx   = idx_reg;
   assign gnt_valid = valid_reg;

endmodule
